or1200_vlx_byte_writer: RTL
===========================

# or1200_vlx_byte_writer

Byte-level write-back stage directly downstream of the VLX bit packer in the OR1200 JPEG path. It accepts packed entropy-coded bytes over a valid/ready handshake, inserts JPEG marker stuffing (0xFF followed by 0x00), and buffers the result in a small FIFO. It then issues single-byte store requests to the data bus at an auto-incrementing address, holding each request until `ack_i`. `busy_o` feeds the CPU stall logic so software cannot read the output address or start a new block while writes are pending.

## Interface
- `FIFO_DEPTH`, 4 — byte FIFO entries; power of two, ≥2.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `byte_valid_i`  in  1  packer presents a byte.
- `byte_i`  in  8  packed byte, MSB-first entropy data.
- `byte_ready_o`  out  1  byte accepted on the edge where valid & ready.
- `init_addr_we_i`  in  1  SPR write of the start address.
- `init_addr_i`  in  32  start address value.
- `store_req_o`  out  1  byte store request; held until ack.
- `store_addr_o`  out  32  byte address of the current store.
- `store_dat_o`  out  32  current byte replicated on all four lanes.
- `store_byte_o`  out  1  byte-size store qualifier; equals `store_req_o`.
- `ack_i`  in  1  bus acknowledge for the current store.
- `next_addr_o`  out  32  address the next byte will be written to (SPR readback).
- `busy_o`  out  1  FIFO non-empty, or FSM not IDLE, or `byte_valid_i`.

## Operation
- **Reset values:** `store_req_o`, `store_byte_o` = 0; `store_addr_o`, `store_dat_o`, `next_addr_o` = 0; `busy_o` = 0; FIFO empty. `byte_ready_o` follows its rule below, so it is 1 out of reset.
- **Acceptance:**
  - `byte_ready_o` = free slots ≥ 2 (stuffing enabled) or ≥ 1 (stuffing disabled).
  - `byte_ready_o` is combinational from the FIFO count only, never from `byte_valid_i`.
- **Stuffing:**
  - An accepted 0xFF pushes 0xFF then 0x00 in the same cycle (two-entry write).
  - All other bytes push one entry.
- **Address register:**
  - `init_addr_we_i` loads `next_addr_o` only when FSM is IDLE and the FIFO is empty. Otherwise the write is ignored; software must poll `busy_o`.
  - Increments by 1 on each acked store, modulo 2^32 (0xFFFFFFFF wraps to 0).
- **FSM:**
  - **IDLE:** if FIFO non-empty, latch the head into `store_dat_o` and `next_addr_o` into `store_addr_o`, then go to REQ.
  - **REQ:** `store_req_o` = 1. On `ack_i`, pop the FIFO, increment `next_addr_o`, and go to IDLE.
  - `ack_i` outside REQ is ignored.
- **Simultaneous push and pop:** allowed in the same cycle. The count changes by (pushed − popped).
- **Full FIFO:** `byte_ready_o` = 0 and the packer must hold its byte; no byte is dropped or overwritten.
- **Empty FIFO:** the FSM stays in IDLE and `store_req_o` = 0.
- **Reset mid-transfer:** `store_req_o` drops immediately (asynchronous), the FIFO is cleared, and any late `ack_i` is ignored.

## Timing
- Byte accepted at edge N → FIFO non-empty after N → IDLE latches at N+1 → `store_req_o` high after edge N+1.
- A stuffed 0x00 follows its 0xFF at the earliest two cycles after the 0xFF's ack (IDLE gap).
- Maximum throughput is one store per two cycles with zero-wait acks.
- `store_addr_o`/`store_dat_o` are stable for the whole REQ period.
- `busy_o` falls on the cycle after the final ack.

## Configuration
- `VLX_STUFF_EN` defined: 0xFF→0xFF,0x00 insertion active; ready requires 2 free slots.
- `VLX_STUFF_EN` undefined: bytes pass through unchanged; ready requires 1 free slot; two-entry push logic removed.

## Structure
- Shared package `vlx_pkg`:
  - FSM state enum {IDLE, REQ}.
  - Constants `JPEG_MARKER` = 8'hFF, `JPEG_STUFF` = 8'h00.
- Sub-module `vlx_byte_fifo`:
  - Parameterized depth.
  - Up to two pushes and one pop per cycle.
  - Exports free-slot count and a head byte.

## Test plan
- Load init addr 0x1000, push 0x12, 0x34, ack each with 1-cycle delay → stores 0x12@0x1000 and 0x34@0x1001; `next_addr_o` = 0x1002.
- Push 0xFF (stuffing on) → stores 0xFF@A then 0x00@A+1; `next_addr_o` = A+2. Same with stuffing off → only 0xFF@A.
- Withhold `ack_i` for 20 cycles while pushing → ready drops once free slots < 2; no byte lost; all bytes stored in order after acks resume.
- Init addr 0xFFFFFFFF, push 2 bytes → stores at 0xFFFFFFFF and 0x00000000.
- `init_addr_we_i` while FIFO non-empty → ignored; it takes effect after `busy_o` = 0.
- Assert `rst_i` during REQ → `store_req_o` 0 immediately; FIFO empty and all outputs 0 thereafter; a subsequent ack has no effect.

Source files
------------

// File: rtl/vlx_pkg.sv
// Shared types and constants for the VLX byte writer: store FSM states and
// the JPEG marker/stuff byte values.
package vlx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } vlx_state_e;

    localparam logic [7:0] JPEG_MARKER = 8'hFF;
    localparam logic [7:0] JPEG_STUFF  = 8'h00;

endpackage

// File: rtl/vlx_byte_fifo.sv
// Byte FIFO for the VLX writer: up to two pushes and one pop per cycle.
// The second write port exists only when VLX_STUFF_EN is defined.
module vlx_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [7:0]                 wdata0,
`ifdef VLX_STUFF_EN
    input  logic                       push2,
    input  logic [7:0]                 wdata1,
`endif
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic [$clog2(DEPTH):0]     free,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] n_push;

`ifdef VLX_STUFF_EN
    assign n_push = push ? (push2 ? CW'(2) : CW'(1)) : CW'(0);
`else
    assign n_push = push ? CW'(1) : CW'(0);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + n_push - CW'(pop);
        end
    end

    // Storage needs no reset; only occupied entries are ever read.
    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= wdata0;
`ifdef VLX_STUFF_EN
        if (push && push2)
            mem[wr_ptr + AW'(1)] <= wdata1;
`endif
    end

    assign head  = mem[rd_ptr];
    assign free  = CW'(DEPTH) - count;
    assign empty = (count == '0);

endmodule

// File: rtl/or1200_vlx_byte_writer.sv
// VLX byte write-back: accepts packed bytes, optionally stuffs 0x00 after
// 0xFF (VLX_STUFF_EN), and issues single-byte stores at an auto-incrementing address.
module or1200_vlx_byte_writer
    import vlx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    input  logic        init_addr_we_i,
    input  logic [31:0] init_addr_i,
    output logic        store_req_o,
    output logic [31:0] store_addr_o,
    output logic [31:0] store_dat_o,
    output logic        store_byte_o,
    input  logic        ack_i,
    output logic [31:0] next_addr_o,
    output logic        busy_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    vlx_state_e    state, state_nxt;
    logic [CW-1:0] free;
    logic [7:0]    head;
    logic          empty, push, pop, latch;

`ifdef VLX_STUFF_EN
    // Room for the worst case (0xFF + stuffed 0x00) regardless of the byte.
    localparam int NEED = 2;
    logic push2;
    assign push2 = (byte_i == JPEG_MARKER);
`else
    localparam int NEED = 1;
`endif

    assign byte_ready_o = (free >= CW'(NEED));
    assign push         = byte_valid_i & byte_ready_o;

    vlx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (push),
        .wdata0 (byte_i),
`ifdef VLX_STUFF_EN
        .push2  (push2),
        .wdata1 (JPEG_STUFF),
`endif
        .pop    (pop),
        .head   (head),
        .free   (free),
        .empty  (empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                latch     = 1'b1;
                state_nxt = REQ;
            end
            REQ: if (ack_i) begin
                pop       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/data are captured once per store so they hold through REQ.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            store_addr_o <= '0;
            store_dat_o  <= '0;
            next_addr_o  <= '0;
        end else begin
            if (latch) begin
                store_addr_o <= next_addr_o;
                store_dat_o  <= {4{head}};
            end
            if (pop)
                next_addr_o <= next_addr_o + 32'd1;
            else if (init_addr_we_i && state == IDLE && empty)
                next_addr_o <= init_addr_i;
        end
    end

    assign store_req_o  = (state == REQ);
    assign store_byte_o = store_req_o;
    assign busy_o       = !empty || (state != IDLE) || byte_valid_i;

endmodule
